// File: rtl/execute_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : execute_pipe
//  Purpose  : Registered execute stage. Single-cycle ALU ops (ADD, SUB, AND,
//             OR, XOR, SLT, SLL, SRL) complete in one cycle. MUL is an
//             iterative shift-add that occupies the stage for XLEN cycles.
//             Valid/ready on both sides, plus a synchronous flush.
//  Ports    : clk, rst_n (async, active-low), flush
//             in_valid/in_ready/in_op/in_a/in_b/in_rd   - upstream side
//             out_valid/out_ready/out_result/out_rd/out_err - downstream side
//             busy - a multiply is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module execute_pipe #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_err,
  output logic            busy
);

  localparam int c_SH_W  = $clog2(XLEN);
  localparam int c_CNT_W = $clog2(XLEN) + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(XLEN);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [3:0] c_OP_ADD = 4'd0;
  localparam logic [3:0] c_OP_SUB = 4'd1;
  localparam logic [3:0] c_OP_AND = 4'd2;
  localparam logic [3:0] c_OP_OR  = 4'd3;
  localparam logic [3:0] c_OP_XOR = 4'd4;
  localparam logic [3:0] c_OP_SLT = 4'd5;
  localparam logic [3:0] c_OP_SLL = 4'd6;
  localparam logic [3:0] c_OP_SRL = 4'd7;
  localparam logic [3:0] c_OP_MUL = 4'd8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t              r_state;
  logic [XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [XLEN-1:0]     r_acc;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [RD_W-1:0]     r_rd_lat;

  logic                w_accept;
  logic [XLEN-1:0]     w_res;
  logic                w_err;
  logic                w_lt;
  logic [c_SH_W-1:0]   w_shamt;
  logic [XLEN-1:0]     w_acc_next;

  // Accept only when idle and the output register is free (or being drained
  // on this same edge); a flush cycle never accepts.
  assign in_ready = (r_state == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;

  assign w_shamt    = in_b[c_SH_W-1:0];
  assign w_lt       = $signed(in_a) < $signed(in_b);
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (in_op)
      c_OP_ADD: w_res = in_a + in_b;
      c_OP_SUB: w_res = in_a - in_b;
      c_OP_AND: w_res = in_a & in_b;
      c_OP_OR:  w_res = in_a | in_b;
      c_OP_XOR: w_res = in_a ^ in_b;
      c_OP_SLT: w_res = {{(XLEN-1){1'b0}}, w_lt};
      c_OP_SLL: w_res = in_a << w_shamt;
      c_OP_SRL: w_res = in_a >> w_shamt;
      c_OP_MUL: w_res = '0;  // produced by the iterative path instead
      default:  w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_rd_lat   <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_err    <= 1'b0;
      busy       <= 1'b0;
    end else if (flush) begin
      // A flushed result is treated as never delivered, even if out_ready
      // was high on the same edge.
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (in_op == c_OP_MUL) begin
              r_mcand  <= in_a;
              r_mplier <= in_b;
              r_acc    <= '0;
              r_cnt    <= c_CNT_INIT;
              r_rd_lat <= in_rd;
              busy     <= 1'b1;
              r_state  <= S_MUL;
            end else begin
              out_valid  <= 1'b1;
              out_result <= w_res;
              out_rd     <= in_rd;
              out_err    <= w_err;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          // Last iteration: the final partial sum goes straight to the
          // output register, which the acceptance rule guarantees is empty.
          if (r_cnt == c_CNT_ONE) begin
            out_valid  <= 1'b1;
            out_result <= w_acc_next;
            out_rd     <= r_rd_lat;
            out_err    <= 1'b0;
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_pipe
//  Purpose  : Directed self-checking bench for execute_pipe (XLEN=32, RD_W=5).
//             Inputs change 1 time unit after the rising edge; outputs are
//             sampled before the next rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_execute_pipe;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_err;
  logic            busy;

  int vectors;
  int miscompares;

  execute_pipe #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_err    (out_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
  endtask

  initial begin
    logic saw_valid;
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);

    // Reset state
    step();
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // ADD wraps: 0xFFFFFFFF + 1 = 0
    drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'h1, 5'd3);
    #1 chk("add_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_result", out_result, 32'h0);
    chk("add_rd", {27'b0, out_rd}, 32'd3);
    chk("add_err", {31'b0, out_err}, 32'd0);

    // Back-to-back single-cycle ops
    drive(1'b1, 4'd1, 32'd5, 32'd7, 5'd4);
    step();
    chk("sub_result", out_result, 32'hFFFF_FFFE);
    chk("sub_rd", {27'b0, out_rd}, 32'd4);
    drive(1'b1, 4'd5, 32'hFFFF_FFFF, 32'd1, 5'd5);
    step();
    chk("slt_result", out_result, 32'd1);
    drive(1'b1, 4'd7, 32'h8000_0000, 32'h21, 5'd6);
    step();
    chk("srl_result", out_result, 32'h4000_0000);
    chk("srl_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b1, 4'd4, 32'h0000_F0F0, 32'h0000_FF00, 5'd7);
    step();
    chk("xor_result", out_result, 32'h0000_0FF0);
    drive(1'b1, 4'd6, 32'd3, 32'h24, 5'd8);
    step();
    chk("sll_result", out_result, 32'h30);
    drive(1'b1, 4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd10);
    step();
    chk("and_result", out_result, 32'h0F00_0F00);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    step();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // MUL 0x12345 * 0x100: busy for 32 cycles, result in cycle N+33
    drive(1'b1, 4'd8, 32'h0001_2345, 32'h100, 5'd9);
    step();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("mul_cycle%0d_busy_rdy_vld", i + 1),
          {29'b0, busy, in_ready, out_valid}, 32'b100);
      step();
    end
    chk("mul_valid", {31'b0, out_valid}, 32'd1);
    chk("mul_result", out_result, 32'h0123_4500);
    chk("mul_rd", {27'b0, out_rd}, 32'd9);
    chk("mul_busy_done", {31'b0, busy}, 32'd0);
    step();

    // Backpressure: result held 4 cycles, then accept on the release cycle
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd10, 32'd20, 5'd7);
    step();
    drive(1'b1, 4'd3, 32'hA0, 32'h0B, 5'd8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d_result", i), out_result, 32'd30);
      chk($sformatf("hold%0d_rdy_vld_rd", i), {26'b0, in_ready, out_valid, out_rd},
          {26'b0, 1'b0, 1'b1, 5'd7});
      step();
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("or_result", out_result, 32'hAB);
    chk("or_rd", {27'b0, out_rd}, 32'd8);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    step();

    // Flush at MUL cycle 10
    drive(1'b1, 4'd8, 32'd3, 32'd5, 5'd2);
    step();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 9; i++) step();
    chk("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    #1 chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_next_in_ready", {31'b0, in_ready}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) saw_valid = 1'b1;
      step();
    end
    chk("flush_no_result", {31'b0, saw_valid}, 32'd0);

    // Flush simultaneous with out_ready drops a held result
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd1);
    step();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    chk("pre_flush_valid", {31'b0, out_valid}, 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_clears_valid", {31'b0, out_valid}, 32'd0);

    // Illegal opcode 12
    drive(1'b1, 4'd12, 32'd5, 32'd6, 5'd11);
    step();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    chk("ill_valid_err", {30'b0, out_valid, out_err}, 32'b11);
    chk("ill_result", out_result, 32'd0);
    chk("ill_rd", {27'b0, out_rd}, 32'd11);

    // Asynchronous reset mid-MUL
    drive(1'b1, 4'd8, 32'd7, 32'd9, 5'd13);
    step();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) step();
    chk("mid_mul_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {out_result, 2'b0, out_rd, out_valid, out_err, busy} == '0 ? 32'd1 : 32'd0, 32'd1);
    chk("arst_rd", {27'b0, out_rd}, 32'd0);
    chk("arst_busy_idle", {30'b0, busy, in_ready}, 32'b01);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 4'd0, 32'd2, 32'd3, 5'd14);
    step();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
    chk("post_rst_add", out_result, 32'd5);
    chk("post_rst_valid_rd", {26'b0, out_valid, out_rd}, {26'b0, 1'b1, 5'd14});
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
